// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_pkg                                                     |
// | Shared encodings and widths for the IF/LS memory port arbiter.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam int c_ADDR_W   = 32;
  localparam int c_DATA_W   = 32;
  localparam int c_STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // Saturating increment so a long LS burst never wraps back below the limit.
  function automatic logic [c_STREAK_W-1:0] streak_next(input logic [c_STREAK_W-1:0] cur);
    return (cur == {c_STREAK_W{1'b1}}) ? cur : cur + 1'b1;
  endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_arb_pick                                                |
// | Combinational winner select; LS first unless ARB_FAIRNESS_EN forces IF.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  i_if_req,
  input  logic                  i_ls_req,
  input  logic [c_STREAK_W-1:0] i_streak,
  output logic                  o_valid,
  output arb_owner_t            o_owner
);

  logic w_force_if;

`ifdef ARB_FAIRNESS_EN
  // IF takes one turn once LS has won MAX_LS_STREAK times in a row over it.
  assign w_force_if = i_if_req && i_ls_req &&
                      (i_streak == c_STREAK_W'(MAX_LS_STREAK));
`else
  logic w_unused_fair;
  assign w_unused_fair = ^{i_streak, c_STREAK_W'(MAX_LS_STREAK)};
  assign w_force_if    = 1'b0;
`endif

  assign o_valid = i_if_req | i_ls_req;
  assign o_owner = (i_ls_req && !w_force_if) ? OWN_LS : OWN_IF;

endmodule : mem_port_arbiter_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one single-port memory between fetch (IF) and load/store (LS),    |
// | one transaction at a time. Optional IF fairness: ARB_FAIRNESS_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = c_ADDR_W,
  parameter int DATA_W        = c_DATA_W,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_wen,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_t            r_state;
  arb_owner_t            r_owner;
  logic                  r_mem_req;
  logic                  r_mem_wen;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_if_rvalid;
  logic                  r_ls_rvalid;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_ls_rdata;

  logic                  w_pick_valid;
  arb_owner_t            w_pick_owner;
  logic                  w_grant;
  logic                  w_capture;
  logic [DATA_W-1:0]     w_resp_data;
  logic [c_STREAK_W-1:0] w_streak;

  mem_port_arbiter_arb_pick #(
    .MAX_LS_STREAK (MAX_LS_STREAK)
  ) u_pick (
    .i_if_req (i_if_req),
    .i_ls_req (i_ls_req),
    .i_streak (w_streak),
    .o_valid  (w_pick_valid),
    .o_owner  (w_pick_owner)
  );

  // Grant is the only combinational output: the requester must see it in the
  // same cycle it is accepted. Gated by rst_n so reset drives every output low.
  assign w_grant  = rst_n && (r_state == ARB_IDLE) && w_pick_valid;
  assign o_if_gnt = w_grant && (w_pick_owner == OWN_IF);
  assign o_ls_gnt = w_grant && (w_pick_owner == OWN_LS);

  // A response is accepted only once the request has been taken; a store
  // acknowledgement returns zero rather than whatever the bus carries.
  assign w_capture   = ((r_state == ARB_ISSUE) && i_mem_ready && i_mem_rvalid) ||
                       ((r_state == ARB_WAIT)  && i_mem_rvalid);
  assign w_resp_data = r_mem_wen ? '0 : i_mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_owner   <= w_pick_owner;
            r_mem_req <= 1'b1;
            if (w_pick_owner == OWN_LS) begin
              r_mem_wen   <= i_ls_wen;
              r_mem_addr  <= i_ls_addr;
              r_mem_wdata <= i_ls_wen ? i_ls_wdata : '0;
            end else begin
              r_mem_wen   <= 1'b0;
              r_mem_addr  <= i_if_addr;
              r_mem_wdata <= '0;
            end
            r_state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= i_mem_rvalid ? ARB_DONE : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (i_mem_rvalid) begin
            r_state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_if_rdata  <= '0;
          r_ls_rdata  <= '0;
          r_state     <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase

      if (w_capture) begin
        r_if_rvalid <= (r_owner == OWN_IF);
        r_ls_rvalid <= (r_owner == OWN_LS);
        r_if_rdata  <= (r_owner == OWN_IF) ? w_resp_data : '0;
        r_ls_rdata  <= (r_owner == OWN_LS) ? w_resp_data : '0;
      end
    end
  end

`ifdef ARB_FAIRNESS_EN
  logic [c_STREAK_W-1:0] r_streak;

  // Counts LS wins that made a waiting IF lose; any other grant restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if ((w_pick_owner == OWN_LS) && i_if_req) begin
        r_streak <= streak_next(r_streak);
      end else begin
        r_streak <= '0;
      end
    end
  end

  assign w_streak = r_streak;
`else
  assign w_streak = '0;
`endif

  assign o_mem_req   = r_mem_req;
  assign o_mem_wen   = r_mem_wen;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_ls_rdata  = r_ls_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction fetch stage (IF) and the load/store unit in the MEM stage (LS). The LS side is driven by the decoder's mem_wen and the wb_sel==WB_MEM control.
- Sequences one transaction at a time: issue, wait for response, return the response to its owner.
- Sits between the pipeline and the memory wrapper. IF stalls on !if_gnt; MEM stalls until ls_rvalid.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF waits. Used only with ARB_FAIRNESS_EN. Range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch accepted by the arbiter.
- if_rvalid  out  1  one-cycle pulse: fetch data valid.
- if_rdata  out  DATA_W  fetch data; valid only with if_rvalid.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_wen  in  1  1 = store (decoder mem_wen), 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  one-cycle pulse: LS accepted.
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- ls_rdata  out  DATA_W  load data; 0 on a store acknowledgement.
- mem_req  out  1  memory request; held until mem_ready.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts a request this cycle.
- mem_rvalid  in  1  memory response valid (reads and writes).
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst_n==0 at a rising edge): state=IDLE. All outputs 0: gnt, rvalid, mem_req, mem_wen, addr/data buses. Streak counter 0.
- Reset mid-transaction abandons it: no rvalid is ever produced for it, and any later mem_rvalid is ignored while in IDLE.
- FSM states:
  - IDLE: if any request is present, select a winner. Register winner, addr, wen and wdata. Pulse the winner's gnt in the same cycle. Go to ISSUE.
  - ISSUE: mem_req=1 with the registered fields. On mem_ready go to WAIT, or to DONE if mem_rvalid is also high in the same cycle.
  - WAIT: hold until mem_rvalid. Capture mem_rdata, go to DONE.
  - DONE: pulse the owner's rvalid with the captured data. Return to IDLE.
- Latency: request-to-rvalid is at least 3 cycles with a memory that accepts immediately and answers next cycle.
- One outstanding transaction. A new grant happens only in IDLE, so at most one grant per 3 cycles.
- Arbitration: LS has priority over IF (older instruction; avoids pipeline deadlock). When both request in IDLE, LS wins.
- mem_* outputs are registered. mem_wen=0 and mem_wdata=0 for fetches.
- Requesters must hold req and its payload stable until gnt. The arbiter does not check this.
- A requester dropping req before gnt is legal and is simply not granted.
- if_rvalid and ls_rvalid are never high in the same cycle.
- A mem_rvalid outside WAIT/ISSUE is ignored.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit streak counter increments on each LS grant made while if_req is high.
  - It clears on any IF grant, or on an LS grant made with if_req low.
  - When streak==MAX_LS_STREAK and both requesters are present, IF wins.
- Not defined: strict LS priority; no counter logic is generated.

Decomposition:
- define.vh (shared header) gets:
  - FSM state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE (2-bit).
  - Owner encodings OWN_IF/OWN_LS.
  - Widths reused by the decoder/top.
- One sub-module is natural: arb_pick. It is the combinational winner select, including the fairness counter compare.

Test Plan:
- Single load, ls_addr=0x100, memory answers 0xDEADBEEF one cycle after accept → ls_gnt at cycle 0, mem_req cycle 1, ls_rvalid cycle 3 with ls_rdata=0xDEADBEEF; if_* stay 0.
- if_req and ls_req both high continuously, fairness off → every grant goes to LS and if_gnt never asserts (starvation documented).
- Same stimulus with ARB_FAIRNESS_EN, MAX_LS_STREAK=2 → grant sequence LS, LS, IF, LS, LS, IF.
- Store ls_wen=1, addr=0x40, wdata=0x12345678, mem_ready delayed 3 cycles → mem_req held 3 cycles with stable fields; ls_rvalid=1 with ls_rdata=0; no if_rvalid.
- rst_n=0 driven while in WAIT, memory returns data 2 cycles later → no rvalid; all outputs 0; next fetch completes normally.
- mem_ready and mem_rvalid high in the same ISSUE cycle → WAIT is skipped and rvalid appears the next cycle with the correct data.
